boot_ctrl: RTL and testbench
============================

Name: boot_ctrl

Overview:
- Sequences the instruction-memory boot path after reset.
- Receives a length-prefixed program as a byte stream from the UART receiver and packs it into 32-bit words written into the INST_BRAM write port.
- Then drives fetch mode through LOAD, so fetch copies the BRAM into its local instruction array, and then EXEC.
- Owns the mode bus and handles halt and error conditions.

Parameters:
ADDR_W, INST_SIZE (constant package), width of the instruction word address.
TIMEOUT, 32'd100000, max clk cycles allowed between bytes of an in-progress transfer.

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active-low
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
fetch_done  in  1  fetch reports local copy complete (level)
halt  in  1  core executed halt (level or pulse)
bram_addr  out  ADDR_W  INST_BRAM write address (word index)
bram_din  out  32  INST_BRAM write data
bram_we  out  1  INST_BRAM write enable, one-cycle pulse
mode  out  3  fetch/core mode: MODE_STALL / MODE_LOAD / MODE_EXEC
words_loaded  out  ADDR_W+1  count of program words written
err  out  1  sticky error flag

Behaviour:
- Reset: synchronous on rstn=0 at the clk edge. All outputs return to their reset values from any state.
  - mode=MODE_STALL, bram_we=0, bram_addr=0, bram_din=0, words_loaded=0, err=0.
  - state=HDR. Byte counter, shift register and gap counter cleared. A partial word is discarded.
- States: HDR, BODY, COPY, RUN, HALT, ERR.
- HDR (mode=STALL): collect 4 bytes into N, big-endian (first byte = MSB). On the 4th byte:
  - N > 2**ADDR_W -> ERR.
  - N == 0 -> COPY.
  - otherwise -> BODY.
- BODY (mode=STALL): bytes are packed big-endian.
  - The cycle after the 4th byte of a word: bram_we=1 for exactly one cycle, bram_addr=word index, bram_din=packed word.
  - words_loaded increments on that same cycle.
  - When words_loaded reaches N, the next state is COPY.
  - A byte arriving on the write cycle is accepted normally. The packer never stalls, so bytes can arrive every cycle.
- COPY (mode=MODE_LOAD): hold until fetch_done=1, then RUN on the next edge. fetch_done sampled in any other state is ignored.
- RUN (mode=MODE_EXEC): halt=1 -> HALT on the next edge.
- HALT (mode=STALL): terminal until reset.
- ERR (mode=STALL, err=1): terminal until reset.
- Gap timeout:
  - Gap counter runs in HDR (only after the first header byte) and in BODY.
  - It resets on every accepted byte. When it reaches TIMEOUT -> ERR.
  - If rx_valid arrives on the same cycle as expiry, the byte wins: it is accepted and the counter is cleared.
- rx_valid in COPY/RUN/HALT/ERR: ignored, with no side effects.
- halt outside RUN: ignored.
- bram_we is never asserted outside BODY.
- Widths: N is held as 32 bits and compared unextended against 2**ADDR_W. The word index never wraps because N ≤ 2**ADDR_W.
- Latency:
  - Last byte of a word -> bram_we: 1 cycle.
  - Last program write -> mode=LOAD: 1 cycle.
  - fetch_done -> mode=EXEC: 1 cycle.

Decomposition:
- Constant package: MODE_STALL=3'd0, MODE_LOAD=3'd1, MODE_EXEC=3'd2 (shared with fetch and the core); INST_SIZE; typedef enum boot_state_t {HDR, BODY, COPY, RUN, HALT, ERR}.
- One sub-module: byte_packer.
  - Contains the 2-bit byte counter and the 32-bit shift register.
  - Outputs a word_valid pulse plus the word.
  - Has a synchronous clear input, used at reset and on HDR->BODY.

Test Plan:
- Normal boot: header 00 00 00 02, body DE AD BE EF 01 02 03 04 back-to-back -> writes addr0=DEADBEEF, addr1=01020304, each with a 1-cycle bram_we. words_loaded=2. mode=LOAD one cycle after the second write. fetch_done=1 -> mode=EXEC one cycle later.
- Zero length: header 00 00 00 00 -> no bram_we; mode=LOAD the cycle after the 4th byte.
- Oversize: with ADDR_W=4, header 00 00 00 11 -> err=1, mode=STALL, no bram_we. Further bytes are ignored.
- Timeout: with TIMEOUT=8, header N=1 then 2 body bytes followed by silence -> err=1 exactly 8 cycles after the last byte. Repeat with a byte arriving on the expiry cycle -> no error.
- Halt and stray input: in RUN, pulse rx_valid (no effect), then halt=1 -> mode=STALL next cycle and stays STALL after halt drops.
- Reset mid-BODY: rstn=0 after 2 of 4 bytes of word 0 -> all outputs reset. A fresh header+body then loads correctly from addr0 with no stale bytes in the word.

Source files
------------

// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg: mode bus encodings shared with fetch and the core, instruction
// memory sizing and the boot sequencer state type.
package boot_ctrl_pkg;

   localparam logic [2:0] MODE_STALL = 3'd0;
   localparam logic [2:0] MODE_LOAD  = 3'd1;
   localparam logic [2:0] MODE_EXEC  = 3'd2;

   localparam int INST_SIZE = 10;

   typedef enum logic [2:0] {HDR, BODY, COPY, RUN, HALT, ERR} boot_state_t;

   function automatic logic [2:0] state_mode(input boot_state_t s);
      return s == COPY ? MODE_LOAD : s == RUN ? MODE_EXEC : MODE_STALL;
   endfunction

endpackage

// File: rtl/boot_ctrl_packer.sv
// byte_packer: assembles a byte stream into big-endian 32-bit words; the fourth
// byte is combined directly so word_valid fires in the same cycle it arrives.
module byte_packer (
   input  logic        clk,
   input  logic        clr,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        word_valid,
   output logic [31:0] word,
   output logic [1:0]  byte_cnt
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] sh_q, sh_d;

   always_comb begin
      cnt_d = clr ? 2'd0 : in_valid ? cnt_q + 2'd1 : cnt_q;
      sh_d  = clr ? 24'd0 : in_valid ? {sh_q[15:0], in_data} : sh_q;
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
   end

   assign word_valid = in_valid && cnt_q == 2'd3;
   assign word       = {sh_q, in_data};
   assign byte_cnt   = cnt_q;

endmodule

// File: rtl/boot_ctrl.sv
// boot_ctrl: loads a length-prefixed program from the UART byte stream into
// INST_BRAM, then steps fetch through LOAD and EXEC; halt and errors are terminal.
module boot_ctrl
   import boot_ctrl_pkg::*;
#(
   parameter int          ADDR_W  = INST_SIZE,
   parameter logic [31:0] TIMEOUT = 32'd100000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              fetch_done,
   input  logic              halt,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [31:0]       bram_din,
   output logic              bram_we,
   output logic [2:0]        mode,
   output logic [ADDR_W:0]   words_loaded,
   output logic              err
);

   localparam logic [32:0] MAX_N = 33'd1 << ADDR_W;

   boot_state_t       state_q, state_d;
   logic [31:0]       n_q, n_d;
   logic [31:0]       gap_q, gap_d;
   logic [ADDR_W:0]   wl_q, wl_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       din_q, din_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [2:0]        mode_q, mode_d;
   logic              acc, gap_on, pk_clr, pk_valid;
   logic [31:0]       pk_word;
   logic [1:0]        pk_cnt;

   assign acc    = rx_valid && (state_q == HDR || state_q == BODY);
   assign pk_clr = !rstn || (state_q == HDR && state_d == BODY);

   byte_packer u_packer (
      .clk        (clk),
      .clr        (pk_clr),
      .in_valid   (acc),
      .in_data    (rx_data),
      .word_valid (pk_valid),
      .word       (pk_word),
      .byte_cnt   (pk_cnt)
   );

   // gap_q counts cycles since the last accepted byte, starting at 1 on the byte itself
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wl_d    = wl_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      gap_on  = state_q == BODY || (state_q == HDR && pk_cnt != 2'd0);
      gap_d   = acc ? 32'd1 : gap_on ? gap_q + 32'd1 : 32'd0;
      case (state_q)
         HDR:
            if (pk_valid) begin
               n_d     = pk_word;
               state_d = {1'b0, pk_word} > MAX_N ? ERR : pk_word == 32'd0 ? COPY : BODY;
            end
         BODY:
            if (we_q && 32'(wl_q) == n_q)
               state_d = COPY;
            else if (pk_valid) begin
               we_d   = 1'b1;
               addr_d = wl_q[ADDR_W-1:0];
               din_d  = pk_word;
               wl_d   = wl_q + (ADDR_W+1)'(1);
            end
         COPY:
            if (fetch_done) state_d = RUN;
         RUN:
            if (halt) state_d = HALT;
         default: ;
      endcase
      if (gap_on && !acc && gap_q == TIMEOUT - 32'd1) state_d = ERR;
      mode_d = state_mode(state_d);
      err_d  = state_d == ERR;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= HDR;
         n_q     <= 32'd0;
         gap_q   <= 32'd0;
         wl_q    <= '0;
         addr_q  <= '0;
         din_q   <= 32'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         mode_q  <= MODE_STALL;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         gap_q   <= gap_d;
         wl_q    <= wl_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         we_q    <= we_d;
         err_q   <= err_d;
         mode_q  <= mode_d;
      end
   end

   assign bram_addr    = addr_q;
   assign bram_din     = din_q;
   assign bram_we      = we_q;
   assign mode         = mode_q;
   assign words_loaded = wl_q;
   assign err          = err_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: vector table for a full boot, directed corner sequences and
// randomized programs checked against an expected word list.
module tb_boot_ctrl;
   import boot_ctrl_pkg::*;

   localparam int AW = 4;

   typedef struct packed {
      logic          v;
      logic [7:0]    d;
      logic          fd;
      logic          h;
      logic [2:0]    m;
      logic          we;
      logic [31:0]   din;
      logic [AW:0]   wl;
   } vec_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          fetch_done = 1'b0;
   logic          halt = 1'b0;
   logic [AW-1:0] bram_addr;
   logic [31:0]   bram_din;
   logic          bram_we;
   logic [2:0]    mode;
   logic [AW:0]   words_loaded;
   logic          err;

   int            n_cmp = 0;
   int            n_bad = 0;
   vec_t          tbl[20];
   logic [AW-1:0] got_a[$];
   logic [31:0]   got_d[$];
   logic [31:0]   exp_w[$];
   int unsigned   n, base;
   logic [31:0]   w;

   boot_ctrl #(.ADDR_W(AW), .TIMEOUT(32'd8)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .fetch_done   (fetch_done),
      .halt         (halt),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din),
      .bram_we      (bram_we),
      .mode         (mode),
      .words_loaded (words_loaded),
      .err          (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rstn && bram_we) begin
         got_a.push_back(bram_addr);
         got_d.push_back(bram_din);
      end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finish");
      $fatal(1);
   end

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic fd, input logic h,
                               input logic [2:0] m, input logic we, input logic [31:0] din,
                               input logic [AW:0] wl);
      vec_t r;
      r.v = v; r.d = d; r.fd = fd; r.h = h; r.m = m; r.we = we; r.din = din; r.wl = wl;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] d, input logic fd, input logic h);
      @(negedge clk);
      rx_valid = v;
      rx_data = d;
      fetch_done = fd;
      halt = h;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic send_word(input logic [31:0] x, input int gmax);
      for (int i = 0; i < 4; i++) begin
         send(x[31-8*i -: 8]);
         if (i < 3) idle(int'($urandom_range(0, gmax)));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      fetch_done = 1'b0;
      halt = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".mode"}, 64'(mode), 64'(MODE_STALL));
      chk({tag, ".we"}, 64'(bram_we), 64'(1'b0));
      chk({tag, ".addr"}, 64'(bram_addr), 64'(0));
      chk({tag, ".din"}, 64'(bram_din), 64'(0));
      chk({tag, ".wl"}, 64'(words_loaded), 64'(0));
      chk({tag, ".err"}, 64'(err), 64'(1'b0));
   endtask

   initial begin
      tbl[0]  = mk(1'b1, 8'h00, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd0);
      tbl[1]  = mk(1'b1, 8'h00, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd0);
      tbl[2]  = mk(1'b1, 8'h00, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd0);
      tbl[3]  = mk(1'b1, 8'h02, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd0);
      tbl[4]  = mk(1'b1, 8'hDE, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd0);
      tbl[5]  = mk(1'b1, 8'hAD, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd0);
      tbl[6]  = mk(1'b1, 8'hBE, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd0);
      tbl[7]  = mk(1'b1, 8'hEF, 1'b0, 1'b0, MODE_STALL, 1'b1, 32'hDEADBEEF, 5'd1);
      tbl[8]  = mk(1'b1, 8'h01, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd1);
      tbl[9]  = mk(1'b1, 8'h02, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd1);
      tbl[10] = mk(1'b1, 8'h03, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd1);
      tbl[11] = mk(1'b1, 8'h04, 1'b0, 1'b0, MODE_STALL, 1'b1, 32'h01020304, 5'd2);
      tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, MODE_LOAD,  1'b0, 32'h0, 5'd2);
      tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, MODE_LOAD,  1'b0, 32'h0, 5'd2);
      tbl[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, MODE_EXEC,  1'b0, 32'h0, 5'd2);
      tbl[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, MODE_EXEC,  1'b0, 32'h0, 5'd2);
      tbl[16] = mk(1'b1, 8'h55, 1'b0, 1'b0, MODE_EXEC,  1'b0, 32'h0, 5'd2);
      tbl[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, MODE_STALL, 1'b0, 32'h0, 5'd2);
      tbl[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd2);
      tbl[19] = mk(1'b0, 8'h00, 1'b1, 1'b0, MODE_STALL, 1'b0, 32'h0, 5'd2);

      do_reset();
      check_reset("rst0");
      idle(20);
      chk("hdr_idle.err", 64'(err), 64'(1'b0));

      for (int i = 0; i < 20; i++) begin
         cyc(tbl[i].v, tbl[i].d, tbl[i].fd, tbl[i].h);
         chk($sformatf("vec%0d.mode", i), 64'(mode), 64'(tbl[i].m));
         chk($sformatf("vec%0d.we", i), 64'(bram_we), 64'(tbl[i].we));
         chk($sformatf("vec%0d.wl", i), 64'(words_loaded), 64'(tbl[i].wl));
         chk($sformatf("vec%0d.err", i), 64'(err), 64'(1'b0));
         if (tbl[i].we) begin
            chk($sformatf("vec%0d.addr", i), 64'(bram_addr), 64'(tbl[i].wl - 5'd1));
            chk($sformatf("vec%0d.din", i), 64'(bram_din), 64'(tbl[i].din));
         end
      end

      do_reset();
      check_reset("rst_from_halt");

      base = got_a.size();
      send_word(32'h0, 0);
      chk("zero.mode", 64'(mode), 64'(MODE_LOAD));
      idle(2);
      chk("zero.writes", 64'(got_a.size() - base), 64'(0));
      chk("zero.mode_hold", 64'(mode), 64'(MODE_LOAD));

      do_reset();
      base = got_a.size();
      send_word(32'h11, 0);
      chk("over.err", 64'(err), 64'(1'b1));
      chk("over.mode", 64'(mode), 64'(MODE_STALL));
      send_word(32'h1, 0);
      send_word(32'hDEADBEEF, 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("over.err_hold", 64'(err), 64'(1'b1));
      chk("over.mode_hold", 64'(mode), 64'(MODE_STALL));
      chk("over.wl", 64'(words_loaded), 64'(0));
      chk("over.writes", 64'(got_a.size() - base), 64'(0));

      do_reset();
      send(8'h00);
      idle(6);
      chk("hdr_to.err_before", 64'(err), 64'(1'b0));
      idle(1);
      chk("hdr_to.err", 64'(err), 64'(1'b1));

      do_reset();
      send_word(32'h1, 0);
      send(8'hA1);
      send(8'hA2);
      chk("body_to.err1", 64'(err), 64'(1'b0));
      for (int j = 2; j <= 8; j++) begin
         idle(1);
         chk($sformatf("body_to.err%0d", j), 64'(err), 64'(j == 8));
      end
      chk("body_to.mode", 64'(mode), 64'(MODE_STALL));

      do_reset();
      send_word(32'h1, 0);
      send(8'hB1);
      send(8'hB2);
      idle(6);
      send(8'hB3);
      chk("byte_wins.err", 64'(err), 64'(1'b0));
      send(8'hB4);
      chk("byte_wins.we", 64'(bram_we), 64'(1'b1));
      chk("byte_wins.din", 64'(bram_din), 64'(32'hB1B2B3B4));
      idle(1);
      chk("byte_wins.mode", 64'(mode), 64'(MODE_LOAD));
      chk("byte_wins.err_after", 64'(err), 64'(1'b0));

      do_reset();
      send_word(32'h1, 0);
      send(8'hAA);
      send(8'hBB);
      do_reset();
      check_reset("rst_mid_body");
      send_word(32'h1, 0);
      send_word(32'h55667788, 0);
      chk("fresh.we", 64'(bram_we), 64'(1'b1));
      chk("fresh.addr", 64'(bram_addr), 64'(0));
      chk("fresh.din", 64'(bram_din), 64'(32'h55667788));
      idle(1);
      chk("fresh.mode", 64'(mode), 64'(MODE_LOAD));
      chk("fresh.wl", 64'(words_loaded), 64'(1));

      for (int it = 0; it < 10; it++) begin
         do_reset();
         n = it == 0 ? 16 : it == 1 ? 0 : $urandom_range(1, 16);
         exp_w.delete();
         base = got_a.size();
         send_word(n, 5);
         for (int k = 0; k < int'(n); k++) begin
            idle(int'($urandom_range(0, 5)));
            w = $urandom;
            exp_w.push_back(w);
            send_word(w, 5);
         end
         if (n != 0) begin
            chk($sformatf("rnd%0d.last_we", it), 64'(bram_we), 64'(1'b1));
            idle(1);
         end
         chk($sformatf("rnd%0d.mode_load", it), 64'(mode), 64'(MODE_LOAD));
         chk($sformatf("rnd%0d.writes", it), 64'(got_a.size() - base), 64'(n));
         for (int k = 0; k < int'(n); k++)
            if (base + k < got_a.size()) begin
               chk($sformatf("rnd%0d.addr%0d", it, k), 64'(got_a[base+k]), 64'(k));
               chk($sformatf("rnd%0d.din%0d", it, k), 64'(got_d[base+k]), 64'(exp_w[k]));
            end
         chk($sformatf("rnd%0d.wl", it), 64'(words_loaded), 64'(n));
         chk($sformatf("rnd%0d.err", it), 64'(err), 64'(1'b0));
         idle(int'($urandom_range(0, 3)));
         chk($sformatf("rnd%0d.mode_wait", it), 64'(mode), 64'(MODE_LOAD));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk($sformatf("rnd%0d.mode_exec", it), 64'(mode), 64'(MODE_EXEC));
      end

      for (int it = 0; it < 4; it++) begin
         do_reset();
         n = it == 0 ? 17 : it == 1 ? 32'hFFFF_FFFF : $urandom_range(18, 32'h7FFF_FFFF);
         base = got_a.size();
         send_word(n, 3);
         chk($sformatf("rnd_over%0d.err", it), 64'(err), 64'(1'b1));
         send_word($urandom, 0);
         chk($sformatf("rnd_over%0d.writes", it), 64'(got_a.size() - base), 64'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
